// File: rtl/sysarr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sysarr_pkg : shared constants and state type for the sequencer   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sysarr_pkg;

    localparam int c_MATRIX_SIZE    = 8;
    localparam int c_DATA_BW        = 8;
    localparam int c_WEIGHT_BW      = 8;
    localparam int c_PARTIAL_SUM_BW = 19;
    localparam int c_VEC_CNT_BW     = 8;
    localparam int c_RES_LAT        = 8;
    localparam int c_ADDR_BW        = $clog2(c_MATRIX_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sysarr_ctrl_skew_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | skew_buffer : triangular delay line, lane i delayed i+1 cycles   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module skew_buffer
    import sysarr_pkg::*;
#(
    parameter int LANES   = c_MATRIX_SIZE,
    parameter int DATA_BW = c_DATA_BW
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_clr,
    input  logic                     i_valid,
    input  logic [LANES*DATA_BW-1:0] i_data,
    output logic [LANES*DATA_BW-1:0] o_data
);

    // Lane 0 occupies the MSBs on both sides.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_BW-1:0] r_data [0:i];
        logic [i:0]         r_vld;

        always_ff @(posedge clk) begin
            if (!rstn || i_clr) begin
                r_vld <= '0;
                for (int s = 0; s <= i; s++) begin
                    r_data[s] <= '0;
                end
            end else begin
                r_vld[0]  <= i_valid;
                r_data[0] <= i_data[(LANES-1-i)*DATA_BW +: DATA_BW];
                for (int s = 1; s <= i; s++) begin
                    r_vld[s]  <= r_vld[s-1];
                    r_data[s] <= r_data[s-1];
                end
            end
        end

        assign o_data[(LANES-1-i)*DATA_BW +: DATA_BW] = r_vld[i] ? r_data[i] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/sysarr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sysarr_ctrl : weight preload, skewed input stream, result tags   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sysarr_ctrl
    import sysarr_pkg::*;
#(
    parameter int MATRIX_SIZE = c_MATRIX_SIZE,
    parameter int DATA_BW     = c_DATA_BW,
    parameter int WEIGHT_BW   = c_WEIGHT_BW,
    parameter int VEC_CNT_BW  = c_VEC_CNT_BW,
    parameter int RES_LAT     = c_RES_LAT,
    parameter int ADDR_BW     = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic                             abort,
    input  logic [VEC_CNT_BW-1:0]            num_vec,
    output logic                             busy,
    output logic                             done,
    output logic                             w_rd_en,
    output logic [ADDR_BW-1:0]               w_rd_addr,
    input  logic [MATRIX_SIZE*WEIGHT_BW-1:0] w_rd_data,
    output logic                             x_rd_en,
    output logic [VEC_CNT_BW-1:0]            x_rd_addr,
    input  logic [MATRIX_SIZE*DATA_BW-1:0]   x_rd_data,
    output logic                             we_rl,
    output logic [MATRIX_SIZE*WEIGHT_BW-1:0] WEIGHTS,
    output logic [MATRIX_SIZE*DATA_BW-1:0]   DIN,
    output logic                             res_valid,
    output logic [VEC_CNT_BW-1:0]            res_idx
);

    state_t                           r_state;
    state_t                           w_next;
    logic [VEC_CNT_BW-1:0]            r_cnt;
    logic [VEC_CNT_BW-1:0]            r_num_vec;
    logic                             r_we_rl;
    logic [MATRIX_SIZE*WEIGHT_BW-1:0] r_weights;
    logic [RES_LAT:0]                 r_res_vld;
    logic [VEC_CNT_BW-1:0]            r_res_idx [0:RES_LAT];
    logic                             w_load_last;
    logic                             w_stream_last;
    logic                             w_drain_last;

    assign w_load_last   = (r_cnt == VEC_CNT_BW'(MATRIX_SIZE - 1));
    assign w_stream_last = (r_cnt == r_num_vec - VEC_CNT_BW'(1));
    assign w_drain_last  = r_res_vld[RES_LAT] &&
                           (r_res_idx[RES_LAT] == r_num_vec - VEC_CNT_BW'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_LOAD_W;
            ST_LOAD_W: if (w_load_last) w_next = (r_num_vec == '0) ? ST_DONE : ST_STREAM;
            ST_STREAM: if (w_stream_last) w_next = ST_DRAIN;
            ST_DRAIN:  if (w_drain_last) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (abort) begin
            w_next = ST_IDLE;
        end
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        w_rd_en   = (r_state == ST_LOAD_W);
        x_rd_en   = (r_state == ST_STREAM);
        w_rd_addr = w_rd_en ? r_cnt[ADDR_BW-1:0] : '0;
        x_rd_addr = x_rd_en ? r_cnt : '0;
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_num_vec <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + VEC_CNT_BW'(1);
            if (r_state == ST_IDLE && w_next == ST_LOAD_W) begin
                r_num_vec <= num_vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            r_we_rl   <= 1'b0;
            r_weights <= '0;
        end else begin
            r_we_rl <= w_rd_en;
            if (w_rd_en) begin
                r_weights <= w_rd_data;
            end
        end
    end

    // Stage 0 lines up with lane 0 on DIN; the last stage is the result tag.
    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            r_res_vld <= '0;
            for (int s = 0; s <= RES_LAT; s++) begin
                r_res_idx[s] <= '0;
            end
        end else begin
            r_res_vld[0] <= x_rd_en;
            r_res_idx[0] <= x_rd_addr;
            for (int s = 1; s <= RES_LAT; s++) begin
                r_res_vld[s] <= r_res_vld[s-1];
                r_res_idx[s] <= r_res_idx[s-1];
            end
        end
    end

    assign we_rl     = r_we_rl;
    assign WEIGHTS   = r_weights;
    assign res_valid = r_res_vld[RES_LAT];
    assign res_idx   = r_res_idx[RES_LAT];

    skew_buffer #(
        .LANES   (MATRIX_SIZE),
        .DATA_BW (DATA_BW)
    ) u_din_skew (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (abort),
        .i_valid (x_rd_en),
        .i_data  (x_rd_data),
        .o_data  (DIN)
    );

endmodule
`default_nettype wire

// File: tb/tb_sysarr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sysarr_ctrl : randomized jobs against a cycle-schedule model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sysarr_ctrl;

    localparam int M   = 8;
    localparam int DBW = 8;
    localparam int WBW = 8;
    localparam int VBW = 8;
    localparam int RL  = 8;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [VBW-1:0]     num_vec = '0;
    logic               busy, done, w_rd_en, x_rd_en, we_rl, res_valid;
    logic [2:0]         w_rd_addr;
    logic [VBW-1:0]     x_rd_addr, res_idx;
    logic [M*WBW-1:0]   w_rd_data, WEIGHTS;
    logic [M*DBW-1:0]   x_rd_data, DIN;

    logic [M*WBW-1:0]   w_mem [0:M-1];
    logic [M*DBW-1:0]   x_mem [0:255];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int jn    = 0;
    int done_c = 0;
    bit job   = 1'b0;
    bit w_zero = 1'b1;

    assign w_rd_data = w_mem[w_rd_addr];
    assign x_rd_data = x_mem[x_rd_addr];

    always #5 clk = ~clk;

    sysarr_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .num_vec   (num_vec),
        .busy      (busy),
        .done      (done),
        .w_rd_en   (w_rd_en),
        .w_rd_addr (w_rd_addr),
        .w_rd_data (w_rd_data),
        .x_rd_en   (x_rd_en),
        .x_rd_addr (x_rd_addr),
        .x_rd_data (x_rd_data),
        .we_rl     (we_rl),
        .WEIGHTS   (WEIGHTS),
        .DIN       (DIN),
        .res_valid (res_valid),
        .res_idx   (res_idx)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs come from the job's cycle schedule relative to the start cycle.
    task automatic step();
        logic [63:0] e_din;
        logic [7:0]  lane;
        bit          act;
        int          k;
        @(posedge clk);
        #1;
        cyc++;
        if (job && cyc > done_c) job = 1'b0;
        act   = job;
        e_din = '0;
        for (int i = 0; i < M; i++) begin
            k = cyc - M - 2 - i;
            if (act && k >= 0 && k < jn) begin
                lane = x_mem[k][(M-1-i)*DBW +: DBW];
                e_din[(M-1-i)*DBW +: DBW] = lane;
            end
        end
        k = cyc - M - 2 - RL;
        chk("busy", 64'(busy), 64'(act && cyc >= 1 && cyc <= done_c));
        chk("done", 64'(done), 64'(act && cyc == done_c));
        chk("w_rd_en", 64'(w_rd_en), 64'(act && cyc >= 1 && cyc <= M));
        chk("w_rd_addr", 64'(w_rd_addr), (act && cyc >= 1 && cyc <= M) ? 64'(cyc - 1) : 64'd0);
        chk("we_rl", 64'(we_rl), 64'(act && cyc >= 2 && cyc <= M + 1));
        if (act && cyc >= 2 && cyc <= M + 1) chk("WEIGHTS", WEIGHTS, w_mem[cyc-2]);
        else if (w_zero) chk("WEIGHTS_zero", WEIGHTS, 64'd0);
        chk("x_rd_en", 64'(x_rd_en), 64'(act && cyc >= M + 1 && cyc <= M + jn));
        chk("x_rd_addr", 64'(x_rd_addr),
            (act && cyc >= M + 1 && cyc <= M + jn) ? 64'(cyc - M - 1) : 64'd0);
        chk("DIN", DIN, e_din);
        chk("res_valid", 64'(res_valid), 64'(act && k >= 0 && k < jn));
        chk("res_idx", 64'(res_idx), (act && k >= 0 && k < jn) ? 64'(k) : 64'd0);
    endtask

    task automatic fill();
        for (int r = 0; r < M; r++) w_mem[r] = {$urandom, $urandom};
        for (int v = 0; v < 256; v++) x_mem[v] = {$urandom, $urandom};
    endtask

    task automatic start_job(input int n);
        num_vec = VBW'(n);
        start   = 1'b1;
        job     = 1'b1;
        jn      = n;
        cyc     = 0;
        done_c  = (n == 0) ? M + 1 : M + n + RL + 2;
        w_zero  = 1'b0;
        step();
        start   = 1'b0;
        num_vec = VBW'($urandom);
    endtask

    task automatic run_until_idle();
        int left;
        left = done_c - cyc + 1;
        for (int i = 0; i < left; i++) step();
    endtask

    task automatic kill_step(input bit use_abort);
        if (use_abort) abort = 1'b1;
        else rstn = 1'b0;
        job    = 1'b0;
        w_zero = 1'b1;
        step();
        abort = 1'b0;
        rstn  = 1'b1;
    endtask

    initial begin
        fill();
        repeat (3) step();
        rstn = 1'b1;
        step();

        // Basic job, N=3
        fill();
        start_job(3);
        run_until_idle();

        // Skew pattern, N=1
        fill();
        x_mem[0] = 64'h0102030405060708;
        start_job(1);
        run_until_idle();

        // Empty job
        start_job(0);
        run_until_idle();

        // start during STREAM is ignored
        fill();
        start_job(4);
        repeat (9) step();
        start = 1'b1;
        num_vec = 8'd7;
        step();
        start = 1'b0;
        run_until_idle();

        // abort at cycle 12 of an N=5 job
        fill();
        start_job(5);
        repeat (11) step();
        kill_step(1'b1);
        repeat (15) step();

        // reset at cycle 11, then a fresh N=3 job
        fill();
        start_job(3);
        repeat (10) step();
        kill_step(1'b0);
        step();
        start_job(3);
        run_until_idle();

        repeat (8) begin
            int gap;
            fill();
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step();
            start_job(int'($urandom_range(0, 12)));
            run_until_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
